// File: rtl/burst_line_router_pkg.sv
// Shared encodings for the memory-side line router.
package router_pkg;

  // mem_burst encodings driven on the external bus
  localparam logic [1:0] BURST_SINGLE = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] BURST_WRAP   = 2'b10;

  // Transaction control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/burst_line_router_beat_sequencer.sv
// Maps a beat count onto the beat index inside the line: wrapping from the
// requested word, or counting up from word 0 for line-aligned bursts.
module beat_sequencer #(
  parameter int unsigned IDX_W = 3
) (
  input  logic             wrap,
  input  logic [IDX_W-1:0] start_idx,
  input  logic [IDX_W-1:0] step,
  output logic [IDX_W-1:0] idx
);

  // Modulo-BEATS wrap falls out of the IDX_W-bit truncation
  always_comb begin
    idx = (wrap ? start_idx : '0) + step;
  end

endmodule

// File: rtl/burst_line_router.sv
// Converts one cache-line fill/writeback or one single-word peripheral access
// into memory-bus beats, with pipelined address phases and an ACK timeout.
module burst_line_router
  import router_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BEATS   = 8,
  parameter int unsigned WRAP_EN = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      freeze,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic                      req_single,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W/8-1:0]       req_sel,
  input  logic [DATA_W*BEATS-1:0]   req_wline,
  output logic                      resp_valid,
  output logic                      resp_err,
  output logic [DATA_W*BEATS-1:0]   resp_line,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [1:0]                mem_burst,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W/8-1:0]       mem_sel,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack,
  input  logic                      mem_stall
);

  localparam int unsigned LINE_W = DATA_W * BEATS;
  localparam int unsigned SEL_W  = DATA_W / 8;
  localparam int unsigned OFF    = $clog2(SEL_W);
  localparam int unsigned IDX_W  = $clog2(BEATS);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << (IDX_W + OFF)) - 64'd1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                single_q, single_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          burst_q, burst_d;
  logic                mem_req_q, mem_req_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic [CNT_W-1:0]    total;
  logic [IDX_W-1:0]    start_idx;
  logic [IDX_W-1:0]    issue_idx;
  logic [IDX_W-1:0]    ack_idx;
  logic                seq_wrap;

  // A single access always addresses its own word, so it uses the wrap path with step 0
  assign seq_wrap  = (WRAP_EN != 0) || single_q;
  assign start_idx = addr_q[IDX_W+OFF-1:OFF];
  assign total     = single_q ? CNT_W'(1) : CNT_W'(BEATS);

  beat_sequencer #(.IDX_W(IDX_W)) u_issue_seq (
    .wrap      (seq_wrap),
    .start_idx (start_idx),
    .step      (issue_cnt_q[IDX_W-1:0]),
    .idx       (issue_idx)
  );

  beat_sequencer #(.IDX_W(IDX_W)) u_ack_seq (
    .wrap      (seq_wrap),
    .start_idx (start_idx),
    .step      (ack_cnt_q[IDX_W-1:0]),
    .idx       (ack_idx)
  );

  // Next-state: accept, address issue, ack collection and timeout; freeze holds everything
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    single_d    = single_q;
    sel_d       = sel_q;
    wline_d     = wline_q;
    line_d      = line_q;
    burst_d     = burst_q;
    mem_req_d   = mem_req_q;
    err_d       = err_q;
    issue_cnt_d = issue_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    tmo_d       = tmo_q;
    if (!freeze) begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_d      = req_addr;
            we_d        = req_we;
            single_d    = req_single;
            sel_d       = req_sel;
            wline_d     = req_wline;
            burst_d     = req_single ? BURST_SINGLE :
                          ((WRAP_EN != 0) ? BURST_WRAP : BURST_INCR);
            issue_cnt_d = '0;
            ack_cnt_d   = '0;
            tmo_d       = '0;
            err_d       = 1'b0;
            mem_req_d   = 1'b1;
            state_d     = req_single ? SINGLE : BURST;
          end
        end
        SINGLE, BURST: begin
          if (mem_req_q && !mem_stall) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            if (issue_cnt_d == total) mem_req_d = 1'b0;
          end
          // An ack in the same cycle as the expiry still counts; expiry only aborts an idle wait
          if (mem_ack && (ack_cnt_q < total)) begin
            if (!we_q) line_d[ack_idx*DATA_W +: DATA_W] = mem_rdata;
            ack_cnt_d = ack_cnt_q + CNT_W'(1);
            tmo_d     = '0;
            if (ack_cnt_d == total) state_d = RESP;
          end else if ((TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT))) begin
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            state_d   = RESP;
          end else if (TIMEOUT != 0) begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        RESP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      single_q    <= 1'b0;
      sel_q       <= '0;
      wline_q     <= '0;
      line_q      <= '0;
      burst_q     <= BURST_SINGLE;
      mem_req_q   <= 1'b0;
      err_q       <= 1'b0;
      issue_cnt_q <= '0;
      ack_cnt_q   <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      single_q    <= single_d;
      sel_q       <= sel_d;
      wline_q     <= wline_d;
      line_q      <= line_d;
      burst_q     <= burst_d;
      mem_req_q   <= mem_req_d;
      err_q       <= err_d;
      issue_cnt_q <= issue_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  // Bus-side outputs derive from held registers only, so freeze holds them too
  always_comb begin
    req_ready  = (state_q == IDLE) && !freeze;
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_line  = line_q;
    mem_req    = mem_req_q;
    mem_we     = mem_req_q && we_q;
    mem_burst  = burst_q;
    mem_addr   = (addr_q & ~LINE_MASK) | (ADDR_W'(issue_idx) << OFF);
    mem_sel    = mem_req_q ? (single_q ? sel_q : '1) : '0;
    mem_wdata  = (mem_req_q && we_q) ? wline_q[issue_idx*DATA_W +: DATA_W] : '0;
  end

endmodule

// File: tb/tb_burst_line_router.sv
// Bench for burst_line_router: a WRAP and an INCR instance share one stimulus
// stream; expectations come from a line-level model of beat order and data.
module tb_burst_line_router;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NB  = 8;
  localparam int LW  = DW * NB;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset, freeze, req_valid, req_we, req_single;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_sel;
  logic [LW-1:0] req_wline;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack, mem_stall;

  logic          w_ready, w_rv, w_re, w_mreq, w_mwe;
  logic [LW-1:0] w_line;
  logic [AW-1:0] w_maddr;
  logic [1:0]    w_burst;
  logic [DW-1:0] w_wdata;
  logic [3:0]    w_msel;

  logic          i_ready, i_rv, i_re, i_mreq, i_mwe;
  logic [LW-1:0] i_line;
  logic [AW-1:0] i_maddr;
  logic [1:0]    i_burst;
  logic [DW-1:0] i_wdata;
  logic [3:0]    i_msel;

  logic [LW-1:0] mline_w, mline_i;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  burst_line_router #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB), .WRAP_EN(1), .TIMEOUT(TMO)) dut_w (
    .clk(clk), .reset(reset), .freeze(freeze), .req_valid(req_valid), .req_ready(w_ready),
    .req_we(req_we), .req_single(req_single), .req_addr(req_addr), .req_sel(req_sel),
    .req_wline(req_wline), .resp_valid(w_rv), .resp_err(w_re), .resp_line(w_line),
    .mem_addr(w_maddr), .mem_burst(w_burst), .mem_req(w_mreq), .mem_we(w_mwe),
    .mem_wdata(w_wdata), .mem_sel(w_msel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_stall(mem_stall));

  burst_line_router #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB), .WRAP_EN(0), .TIMEOUT(TMO)) dut_i (
    .clk(clk), .reset(reset), .freeze(freeze), .req_valid(req_valid), .req_ready(i_ready),
    .req_we(req_we), .req_single(req_single), .req_addr(req_addr), .req_sel(req_sel),
    .req_wline(req_wline), .resp_valid(i_rv), .resp_err(i_re), .resp_line(i_line),
    .mem_addr(i_maddr), .mem_burst(i_burst), .mem_req(i_mreq), .mem_we(i_mwe),
    .mem_wdata(i_wdata), .mem_sel(i_msel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_stall(mem_stall));

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word slot of beat n within the line
  function automatic int exp_idx(input bit wrap, input bit single, input logic [AW-1:0] a, input int n);
    int start;
    start = int'((a >> 2) % NB);
    if (single) return start;
    return wrap ? (start + n) % NB : n;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input bit wrap, input bit single, input logic [AW-1:0] a, input int n);
    logic [AW-1:0] line_base;
    line_base = a & ~AW'(4 * NB - 1);
    return line_base + AW'(4 * exp_idx(wrap, single, a, n));
  endfunction

  task automatic check_reset(input string tag);
    check1({tag, "_ready"}, w_ready, 1'b1);
    check1({tag, "_rv"}, w_rv | i_rv, 1'b0);
    check1({tag, "_err"}, w_re | i_re, 1'b0);
    check1({tag, "_req"}, w_mreq | i_mreq, 1'b0);
    check1({tag, "_we"}, w_mwe | i_mwe, 1'b0);
    checkw({tag, "_line"}, w_line | i_line, '0);
    checkw({tag, "_addr"}, LW'(w_maddr | i_maddr), '0);
    checkw({tag, "_burst"}, LW'(w_burst | i_burst), '0);
    checkw({tag, "_sel"}, LW'(w_msel | i_msel), '0);
    checkw({tag, "_wdata"}, LW'(w_wdata | i_wdata), '0);
  endtask

  // One transaction: request, memory responder (one ack per accepted phase, in order), response
  task automatic run_txn(input bit we, input bit single, input logic [AW-1:0] addr, input logic [3:0] sel,
                         input int stall_at, input int stall_len, input bit ack_on);
    int total, issued, t, last_ack, stall_left, n, iw, ii;
    bit stall_done;
    int seen[NB];
    int pend[$];
    logic [LW-1:0] wl;
    total = single ? 1 : NB;
    issued = 0; last_ack = -100; stall_left = 0; stall_done = 1'b0;
    for (int k = 0; k < NB; k++) seen[k] = 0;
    for (int k = 0; k < NB; k++) wl[k*DW +: DW] = $urandom;
    @(negedge clk);
    check1("req_ready", w_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_single = single; req_addr = addr; req_sel = sel; req_wline = wl;
    @(negedge clk);
    req_valid = 1'b0;
    t = 1;
    while (t < 60 && !w_rv) begin
      mem_ack = 1'b0;
      mem_stall = 1'b0;
      if (ack_on && pend.size() > 0) begin
        n = pend.pop_front();
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        last_ack = t;
        if (!we) begin
          mline_w[exp_idx(1'b1, single, addr, n)*DW +: DW] = mem_rdata;
          mline_i[exp_idx(1'b0, single, addr, n)*DW +: DW] = mem_rdata;
        end
      end
      if (issued < total) begin
        if (w_mreq) begin
          iw = exp_idx(1'b1, single, addr, issued);
          ii = exp_idx(1'b0, single, addr, issued);
          checkw("mem_addr_w", LW'(w_maddr), LW'(exp_addr(1'b1, single, addr, issued)));
          checkw("mem_addr_i", LW'(i_maddr), LW'(exp_addr(1'b0, single, addr, issued)));
          checkw("mem_burst_w", LW'(w_burst), LW'(single ? 0 : 2));
          checkw("mem_burst_i", LW'(i_burst), LW'(single ? 0 : 1));
          checkw("mem_sel", LW'(w_msel), LW'(single ? sel : 4'hF));
          check1("mem_we", w_mwe, we);
          checkw("mem_wdata_w", LW'(w_wdata), we ? LW'(wl[iw*DW +: DW]) : '0);
          checkw("mem_wdata_i", LW'(i_wdata), we ? LW'(wl[ii*DW +: DW]) : '0);
          if (!stall_done && issued == stall_at) begin
            stall_done = 1'b1;
            stall_left = stall_len;
          end
          if (stall_left > 0) begin
            mem_stall = 1'b1;
            stall_left--;
          end else begin
            seen[iw]++;
            pend.push_back(issued);
            issued++;
          end
        end
      end else begin
        check1("req_dropped", w_mreq, 1'b0);
        check1("we_dropped", w_mwe, 1'b0);
      end
      @(negedge clk);
      t++;
    end
    mem_ack = 1'b0;
    mem_stall = 1'b0;
    check1("resp_valid", w_rv, 1'b1);
    check1("resp_valid_i", i_rv, 1'b1);
    check1("resp_err", w_re, !ack_on);
    check1("resp_mem_req", w_mreq, 1'b0);
    if (ack_on) begin
      checkw("resp_lat", LW'(t), LW'(last_ack + 1));
      checkw("resp_line_w", w_line, mline_w);
      checkw("resp_line_i", i_line, mline_i);
      if (!single)
        for (int k = 0; k < NB; k++) checkw("slot_once", LW'(seen[k]), LW'(1));
    end else begin
      check1("tmo_window", (t >= 17 && t <= 18), 1'b1);
    end
    @(negedge clk);
    check1("resp_pulse", w_rv, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            r_we, r_sg, seen_rv;
    logic [3:0]    r_sel;
    logic [AW-1:0] fa;
    reset = 1'b1; freeze = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_single = 1'b0;
    req_addr = '0; req_sel = '0; req_wline = '0; mem_rdata = '0; mem_ack = 1'b0; mem_stall = 1'b0;
    mline_w = '0; mline_i = '0;
    repeat (2) @(negedge clk);
    check_reset("init");
    reset = 1'b0;

    // WRAP read burst from 0x1014 (INCR instance sees the same stream)
    run_txn(1'b0, 1'b0, 32'h0000_1014, 4'h0, -1, 0, 1'b1);
    // Write burst with a 2-cycle stall on beat 3
    run_txn(1'b1, 1'b0, 32'h0000_2008, 4'h0, 3, 2, 1'b1);
    // No acks: timeout abort
    run_txn(1'b0, 1'b0, 32'h0000_3000, 4'h0, -1, 0, 1'b0);
    // Full read to refill every slot, then single peripheral read
    run_txn(1'b0, 1'b0, 32'h0000_3004, 4'h0, 1, 1, 1'b1);
    run_txn(1'b0, 1'b1, 32'h4000_0008, 4'b0100, -1, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_sg  = ($urandom_range(0, 3) == 0);
      r_sel = 4'($urandom_range(1, 15));
      run_txn(r_we, r_sg, $urandom, r_sel, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1);
    end

    // Freeze mid-burst, then reset mid-burst
    fa = 32'h5000_0010;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_single = 1'b0; req_addr = fa; req_wline = '0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkw("pre_freeze_addr", LW'(w_maddr), LW'(exp_addr(1'b1, 1'b0, fa, 3)));
    freeze = 1'b1;
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1("frz_ready", w_ready, 1'b0);
      check1("frz_req", w_mreq, 1'b1);
      check1("frz_rv", w_rv, 1'b0);
      checkw("frz_addr_w", LW'(w_maddr), LW'(exp_addr(1'b1, 1'b0, fa, 3)));
      checkw("frz_addr_i", LW'(i_maddr), LW'(exp_addr(1'b0, 1'b0, fa, 3)));
      checkw("frz_burst", LW'(w_burst), LW'(2));
      checkw("frz_line", w_line, mline_w);
    end
    freeze = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    checkw("post_freeze_addr", LW'(w_maddr), LW'(exp_addr(1'b1, 1'b0, fa, 4)));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset("mid_rst");
    mline_w = '0;
    mline_i = '0;
    seen_rv = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (w_rv || i_rv) seen_rv = 1'b1;
    end
    check1("no_resp_after_reset", seen_rv, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
